// File: rtl/tdc_pkg.sv
// tdc_pkg: shared constants and word-field width helpers for the TDC timestamp path
package tdc_pkg;
   localparam int FINE_W = 6;
   localparam int FINE_MAX = 32;
   localparam logic TYPE_HIT = 1'b0;
   localparam logic TYPE_EPOCH = 1'b1;
   function automatic int payload_w(input int coarse_w);
      return coarse_w + FINE_W;
   endfunction
   function automatic int word_w(input int coarse_w);
      return payload_w(coarse_w) + 1;
   endfunction
endpackage

// File: rtl/tdc_timestamp_builder_if.sv
// tdc_timestamp_builder_if: ready/valid readout bus carrying timestamp words
interface tdc_timestamp_builder_if
   import tdc_pkg::*;
#(
   parameter int COARSE_W = 24
);
   logic [word_w(COARSE_W)-1:0] ts_data;
   logic ts_valid;
   logic ts_ready;
   modport master(output ts_data, ts_valid, input ts_ready);
   modport slave(input ts_data, ts_valid, output ts_ready);
endinterface

// File: rtl/tdc_hit_fifo.sv
// tdc_hit_fifo: synchronous first-word-fall-through FIFO with full/empty/count
module tdc_hit_fifo #(
   parameter int W = 31,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_wr, do_rd;
   assign empty = count == '0;
   assign full = count == (AW+1)'(DEPTH);
   assign do_rd = rd_en && !empty;
   // a read in the same cycle frees the slot the write needs
   assign do_wr = wr_en && (!full || do_rd);
   assign rd_data = empty ? '0 : mem[rd_ptr];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
   always_ff @(posedge clk)
      if (do_wr) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/tdc_timestamp_builder.sv
// tdc_timestamp_builder: stamps fine codes with a coarse counter, inserts epoch markers
// on coarse wrap, and queues the words for readout.
module tdc_timestamp_builder
   import tdc_pkg::*;
#(
   parameter int COARSE_W = 24,
   parameter int EPOCH_W = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DEAD_CYC = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tdc_en,
   input  logic                 fine_valid,
   input  logic [FINE_W-1:0]    fine_bin,
   tdc_timestamp_builder_if.master ts,
   output logic [15:0]          drop_cnt,
   output logic                 fine_err
);
   localparam int WW = word_w(COARSE_W);
   localparam int DW = DEAD_CYC > 0 ? $clog2(DEAD_CYC + 1) : 1;
   logic [COARSE_W-1:0] coarse, stg_coarse;
   logic [EPOCH_W-1:0] epoch;
   logic [DW-1:0] dead;
   logic [FINE_W-1:0] stg_fine;
   logic [payload_w(COARSE_W)-1:0] ep_ext;
   logic [WW-1:0] wr_data;
   logic [$clog2(FIFO_DEPTH):0] count_unused;
   logic epoch_pend, stg_valid, accept, wrap, illegal, full, empty, rd, space, hit_wr, mk_wr;
   assign accept = fine_valid && tdc_en && dead == '0;
   assign wrap = tdc_en && &coarse;
   assign illegal = fine_bin > FINE_W'(FINE_MAX);
   assign rd = ts.ts_valid && ts.ts_ready;
   assign space = !full || rd;
   // staged hit wins the single write port; a marker only goes out when it is idle
   assign hit_wr = stg_valid && space;
   assign mk_wr = !stg_valid && epoch_pend && space;
   assign ts.ts_valid = !empty;
   always_comb begin
      ep_ext = '0;
      ep_ext[EPOCH_W-1:0] = epoch;
      wr_data = stg_valid ? {TYPE_HIT, stg_coarse, stg_fine} : {TYPE_EPOCH, ep_ext};
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         coarse <= '0;
         epoch <= '0;
         epoch_pend <= 1'b0;
         dead <= '0;
         stg_valid <= 1'b0;
         stg_coarse <= '0;
         stg_fine <= '0;
         fine_err <= 1'b0;
         drop_cnt <= '0;
      end else begin
         coarse <= tdc_en ? coarse + 1'b1 : '0;
         epoch <= !tdc_en ? '0 : wrap ? epoch + 1'b1 : epoch;
         epoch_pend <= tdc_en && (wrap || (epoch_pend && !mk_wr));
         dead <= !tdc_en ? '0 : accept ? DW'(DEAD_CYC) : dead != '0 ? dead - 1'b1 : '0;
         stg_valid <= accept;
         if (accept) begin
            stg_coarse <= coarse;
            stg_fine <= illegal ? FINE_W'(FINE_MAX) : fine_bin;
         end
         fine_err <= fine_err || (accept && illegal);
         if (stg_valid && !space && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
   tdc_hit_fifo #(.W(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .wr_en(hit_wr || mk_wr),
      .wr_data(wr_data),
      .rd_en(ts.ts_ready),
      .rd_data(ts.ts_data),
      .full(full),
      .empty(empty),
      .count(count_unused)
   );
endmodule

// File: tb/tb_tdc_timestamp_builder.sv
// tb_tdc_timestamp_builder: directed scenarios on a small instance (4-bit coarse, 4-deep FIFO)
module tb_tdc_timestamp_builder;
   logic clk = 1'b0, rst_n = 1'b0, tdc_en = 1'b0, fine_valid = 1'b0;
   logic [5:0] fine_bin = '0;
   logic [15:0] drop_cnt;
   logic fine_err;
   int vectors = 0, miscompares = 0;
   localparam logic [10:0] EP1 = 11'h401;
   tdc_timestamp_builder_if #(.COARSE_W(4)) ts();
   tdc_timestamp_builder #(.COARSE_W(4), .EPOCH_W(8), .FIFO_DEPTH(4), .DEAD_CYC(2)) dut (
      .clk(clk), .rst_n(rst_n), .tdc_en(tdc_en), .fine_valid(fine_valid), .fine_bin(fine_bin),
      .ts(ts), .drop_cnt(drop_cnt), .fine_err(fine_err)
   );
   always #5 clk = ~clk;
   function automatic logic [10:0] hw(input int c, input int f);
      return {1'b0, 4'(c), 6'(f)};
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic restart();
      tdc_en = 1'b0;
      tick();
      tdc_en = 1'b1;
   endtask
   task automatic test_reset();
      ts.ts_ready = 1'b0;
      tick();
      tick();
      vectors++; if (ts.ts_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", ts.ts_valid); end
      vectors++; if (ts.ts_data !== 11'h0) begin miscompares++; $display("FAIL rst_data got %h want 000", ts.ts_data); end
      vectors++; if (drop_cnt !== 16'h0) begin miscompares++; $display("FAIL rst_drop got %h want 0000", drop_cnt); end
      vectors++; if (fine_err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", fine_err); end
      rst_n = 1'b1;
      tick();
   endtask
   task automatic test_hit_timing();
      restart();
      repeat (5) tick();
      fine_valid = 1'b1;
      fine_bin = 6'd13;
      tick();
      fine_valid = 1'b0;
      vectors++; if (ts.ts_valid !== 1'b0) begin miscompares++; $display("FAIL hit_latency got %b want 0", ts.ts_valid); end
      tick();
      vectors++; if (ts.ts_valid !== 1'b1) begin miscompares++; $display("FAIL hit_valid got %b want 1", ts.ts_valid); end
      vectors++; if (ts.ts_data !== hw(5, 13)) begin miscompares++; $display("FAIL hit_data got %h want %h", ts.ts_data, hw(5, 13)); end
      tick();
      vectors++; if (ts.ts_data !== hw(5, 13)) begin miscompares++; $display("FAIL hit_hold got %h want %h", ts.ts_data, hw(5, 13)); end
      ts.ts_ready = 1'b1;
      tick();
      ts.ts_ready = 1'b0;
      vectors++; if (ts.ts_valid !== 1'b0) begin miscompares++; $display("FAIL hit_drain got %b want 0", ts.ts_valid); end
   endtask
   task automatic test_illegal_fine();
      restart();
      fine_valid = 1'b1;
      fine_bin = 6'd40;
      tick();
      fine_valid = 1'b0;
      vectors++; if (fine_err !== 1'b1) begin miscompares++; $display("FAIL err_set got %b want 1", fine_err); end
      tick();
      vectors++; if (ts.ts_data !== hw(0, 32)) begin miscompares++; $display("FAIL err_sat got %h want %h", ts.ts_data, hw(0, 32)); end
      ts.ts_ready = 1'b1;
      tick();
      ts.ts_ready = 1'b0;
      repeat (3) tick();
      vectors++; if (fine_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b want 1", fine_err); end
   endtask
   task automatic test_dead_time();
      restart();
      fine_valid = 1'b1;
      fine_bin = 6'd4;
      repeat (6) tick();
      fine_valid = 1'b0;
      ts.ts_ready = 1'b1;
      vectors++; if (ts.ts_data !== hw(0, 4)) begin miscompares++; $display("FAIL dead_w0 got %h want %h", ts.ts_data, hw(0, 4)); end
      tick();
      vectors++; if (ts.ts_data !== hw(3, 4)) begin miscompares++; $display("FAIL dead_w1 got %h want %h", ts.ts_data, hw(3, 4)); end
      tick();
      vectors++; if (ts.ts_valid !== 1'b0) begin miscompares++; $display("FAIL dead_count got %b want 0", ts.ts_valid); end
      ts.ts_ready = 1'b0;
   endtask
   task automatic test_wrap();
      restart();
      repeat (15) tick();
      fine_valid = 1'b1;
      fine_bin = 6'd9;
      tick();
      fine_valid = 1'b0;
      tick();
      vectors++; if (ts.ts_data !== hw(15, 9)) begin miscompares++; $display("FAIL wrap_hit got %h want %h", ts.ts_data, hw(15, 9)); end
      ts.ts_ready = 1'b1;
      tick();
      vectors++; if (ts.ts_data !== EP1) begin miscompares++; $display("FAIL wrap_epoch got %h want %h", ts.ts_data, EP1); end
      tick();
      vectors++; if (ts.ts_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_empty got %b want 0", ts.ts_valid); end
      ts.ts_ready = 1'b0;
   endtask
   task automatic test_overflow();
      restart();
      fine_valid = 1'b1;
      fine_bin = 6'd7;
      repeat (19) tick();
      fine_valid = 1'b0;
      tick();
      vectors++; if (drop_cnt !== 16'd3) begin miscompares++; $display("FAIL ovf_drops got %0d want 3", drop_cnt); end
      vectors++; if (ts.ts_data !== hw(0, 7)) begin miscompares++; $display("FAIL ovf_w0 got %h want %h", ts.ts_data, hw(0, 7)); end
      ts.ts_ready = 1'b1;
      tick();
      vectors++; if (ts.ts_data !== hw(3, 7)) begin miscompares++; $display("FAIL ovf_w1 got %h want %h", ts.ts_data, hw(3, 7)); end
      tick();
      vectors++; if (ts.ts_data !== hw(6, 7)) begin miscompares++; $display("FAIL ovf_w2 got %h want %h", ts.ts_data, hw(6, 7)); end
      tick();
      vectors++; if (ts.ts_data !== hw(9, 7)) begin miscompares++; $display("FAIL ovf_w3 got %h want %h", ts.ts_data, hw(9, 7)); end
      tick();
      vectors++; if (ts.ts_data !== EP1) begin miscompares++; $display("FAIL ovf_marker got %h want %h", ts.ts_data, EP1); end
      tick();
      vectors++; if (ts.ts_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_empty got %b want 0", ts.ts_valid); end
      ts.ts_ready = 1'b0;
   endtask
   task automatic test_reset_mid();
      restart();
      fine_valid = 1'b1;
      fine_bin = 6'd1;
      repeat (9) tick();
      fine_valid = 1'b0;
      vectors++; if (ts.ts_valid !== 1'b1) begin miscompares++; $display("FAIL mid_queued got %b want 1", ts.ts_valid); end
      rst_n = 1'b0;
      #1;
      vectors++; if (ts.ts_valid !== 1'b0) begin miscompares++; $display("FAIL mid_async got %b want 0", ts.ts_valid); end
      vectors++; if (drop_cnt !== 16'h0) begin miscompares++; $display("FAIL mid_drop got %h want 0000", drop_cnt); end
      vectors++; if (fine_err !== 1'b0) begin miscompares++; $display("FAIL mid_err got %b want 0", fine_err); end
      tick();
      rst_n = 1'b1;
      fine_valid = 1'b1;
      fine_bin = 6'd2;
      tick();
      fine_valid = 1'b0;
      tick();
      vectors++; if (ts.ts_data !== hw(0, 2)) begin miscompares++; $display("FAIL mid_restamp got %h want %h", ts.ts_data, hw(0, 2)); end
      tdc_en = 1'b0;
   endtask
   initial begin
      test_reset();
      test_hit_timing();
      test_illegal_fine();
      test_dead_time();
      test_wrap();
      test_overflow();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
